// File: rtl/ov5640_pkg.sv
// Shared types for the OV5640 DVP transmitter: FSM state encoding and RGB565 colour-bar constants.
package ov5640_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFP    = 3'd5
  } ov5640_state_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/ov5640_bar_gen.sv
// Colour-bar decoder: maps a pixel column to one of eight vertical RGB565 bars.
// Combinational; the caller registers the result into its pixel register on the accept cycle.
module ov5640_bar_gen
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int COLW     = 10
) (
  input  logic [COLW-1:0] col,
  output logic [15:0]     color
);

  localparam int BAR_W = H_ACTIVE / 8;
  // Lines narrower than 8 pixels give each pixel its own bar.
  localparam int BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;

  logic [31:0] bar_idx;

  always_comb begin
    bar_idx = {{(32-COLW){1'b0}}, col} / 32'(BAR_DIV);
    color   = (bar_idx >= 32'd7) ? BAR_BLACK : bar_color(bar_idx[2:0]);
  end

endmodule

// File: rtl/ov5640_dvp_tx.sv
// OV5640-style DVP transmitter: RGB565 stream in, vsync/href/byte-serial data out, high byte first.
// Optional colour-bar source enabled by OV5640_TX_PATTERN_EN (adds pattern_sel input).
module ov5640_dvp_tx
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 16,
  parameter int VSYNC_LEN = 8,
  parameter int V_BP      = 4,
  parameter int V_FP      = 4
) (
  input  logic          ov5640_pclk,
  input  logic          sys_rst,
  input  logic          tx_en,
  input  logic [15:0]   s_pix_data,
  input  logic          s_pix_valid,
`ifdef OV5640_TX_PATTERN_EN
  input  logic          pattern_sel,
`endif
  output logic          s_pix_ready,
  output logic          dvp_vsync,
  output logic          dvp_href,
  output logic [7:0]    dvp_data,
  output logic          frame_start,
  output logic          underrun,
  output ov5640_state_e dbg_state
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int MAXC     = (LINE_LEN > VSYNC_LEN) ? LINE_LEN : VSYNC_LEN;
  localparam int MAXL_A   = (V_BP > V_FP) ? V_BP : V_FP;
  localparam int MAXL     = (V_ACTIVE > MAXL_A) ? V_ACTIVE : MAXL_A;
  localparam int CW       = $clog2(MAXC);
  localparam int LW       = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_LEN - 1);
  localparam logic [CW-1:0] ACT_LAST = CW'(2 * H_ACTIVE - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] LN_LAST  = CW'(LINE_LEN - 1);
  localparam logic [LW-1:0] VBP_LAST = LW'(V_BP - 1);
  localparam logic [LW-1:0] VA_LAST  = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VFP_LAST = LW'(V_FP - 1);

  ov5640_state_e state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [LW-1:0] line, line_n;
  logic [15:0]   pix_q;
  logic [15:0]   src_pix;
  logic          next_active, pix_due, fs_n, use_stream;

  // State, cyc and line describe the cycle currently on the pins; outputs are
  // registered from the next-state values so they change together with the state.
  always_ff @(posedge ov5640_pclk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      cyc   <= '0;
      line  <= '0;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
      line  <= line_n;
    end
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    line_n  = line;
    case (state)
      ST_IDLE: begin
        cyc_n  = '0;
        line_n = '0;
        if (tx_en) state_n = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (cyc == VS_LAST) begin
          state_n = ST_VBP;
          cyc_n   = '0;
          line_n  = '0;
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      ST_VBP: begin
        if (cyc == LN_LAST) begin
          cyc_n = '0;
          if (line == VBP_LAST) begin
            state_n = ST_ACTIVE;
            line_n  = '0;
          end else begin
            line_n = line + LW'(1);
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      ST_ACTIVE: begin
        if (cyc == ACT_LAST) begin
          state_n = ST_HBLANK;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      ST_HBLANK: begin
        if (cyc == HB_LAST) begin
          cyc_n = '0;
          if (line == VA_LAST) begin
            state_n = ST_VFP;
            line_n  = '0;
          end else begin
            state_n = ST_ACTIVE;
            line_n  = line + LW'(1);
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      ST_VFP: begin
        if (cyc == LN_LAST) begin
          cyc_n = '0;
          if (line == VFP_LAST) begin
            state_n = tx_en ? ST_VSYNC : ST_IDLE;
            line_n  = '0;
          end else begin
            line_n = line + LW'(1);
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cyc_n   = '0;
        line_n  = '0;
      end
    endcase
  end

  // Byte phase is cyc[0] inside a line; a pixel is due when the next cycle is phase 0.
  assign next_active = (state_n == ST_ACTIVE);
  assign pix_due     = next_active && !cyc_n[0];
  assign fs_n        = (state_n == ST_VSYNC) && (state != ST_VSYNC);

`ifdef OV5640_TX_PATTERN_EN
  logic        pat_mode;
  logic [15:0] bar_pix;

  ov5640_bar_gen #(
    .H_ACTIVE (H_ACTIVE),
    .COLW     (CW - 1)
  ) u_bar_gen (
    .col   (cyc_n[CW-1:1]),
    .color (bar_pix)
  );

  always_ff @(posedge ov5640_pclk) begin
    if (sys_rst)   pat_mode <= 1'b0;
    else if (fs_n) pat_mode <= pattern_sel;
  end

  assign use_stream = !pat_mode;
  assign src_pix    = pat_mode ? bar_pix : (s_pix_valid ? s_pix_data : 16'h0000);
`else
  assign use_stream = 1'b1;
  assign src_pix    = s_pix_valid ? s_pix_data : 16'h0000;
`endif

  // Handshake: a pixel transfers on a rising edge where s_pix_valid && s_pix_ready.
  // Ready never waits on valid; a missing pixel is replaced by zero and timing keeps running.
  assign s_pix_ready = !sys_rst && pix_due && use_stream;

  always_ff @(posedge ov5640_pclk) begin
    if (sys_rst) begin
      dvp_vsync   <= 1'b0;
      dvp_href    <= 1'b0;
      dvp_data    <= 8'h00;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      pix_q       <= 16'h0000;
    end else begin
      dvp_vsync   <= (state_n == ST_VSYNC);
      dvp_href    <= next_active;
      frame_start <= fs_n;
      if (pix_due) begin
        pix_q    <= src_pix;
        dvp_data <= src_pix[15:8];
        if (use_stream && !s_pix_valid) underrun <= 1'b1;
      end else if (next_active) begin
        dvp_data <= pix_q[7:0];
      end else begin
        dvp_data <= 8'h00;
      end
    end
  end

  assign dbg_state = state;

endmodule
